// File: rtl/ram_access_ctrl_if.sv
// ram_access_ctrl_if: front-panel, CPU control and RAM-side signals of the
// RAM access controller. The master drives panel/CPU inputs; the slave (the
// controller) drives the RAM-facing outputs.
interface ram_access_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              prog_mode;
    logic              addr_button;
    logic              data_button;
    logic [ADDR_W-1:0] dipswitch_addr;
    logic [DATA_W-1:0] dipswitch_data;
    logic              cpu_mi;
    logic              cpu_ri;
    logic              cpu_ro;
    logic [DATA_W-1:0] bus_in;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic              ram_oe;
    logic              busy;

    modport master (
        output prog_mode, addr_button, data_button, dipswitch_addr, dipswitch_data,
        output cpu_mi, cpu_ri, cpu_ro, bus_in,
        input  ram_addr, ram_wdata, ram_we, ram_oe, busy
    );

    modport slave (
        input  prog_mode, addr_button, data_button, dipswitch_addr, dipswitch_data,
        input  cpu_mi, cpu_ri, cpu_ro, bus_in,
        output ram_addr, ram_wdata, ram_we, ram_oe, busy
    );
endinterface

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: sequences all access to the 16x8 RAM and owns the MAR.
// Program mode debounces the panel buttons and performs one action per press
// (load MAR, or a single-cycle write of the DIP data). Run mode passes the CPU
// MI/RI/RO control lines and the bus straight through to the RAM.
// Optional feature macro: AUTO_INC_EN -- each panel data write also advances
// the MAR by one (wrapping), after the write has used the current address.
module ram_access_ctrl #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int DEB_CYC = 4
) (
    input  logic               clk,
    input  logic               reset,
    ram_access_ctrl_if.slave   bus
);
    localparam int              CNT_W    = $clog2(DEB_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    typedef enum logic [1:0] {IDLE, DEB, ACT, REL} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              sel_data, sel_data_nxt;
    logic              wdata_load;

    logic [1:0]        a_sync, d_sync;
    logic              a_s, d_s;
    logic              prog_q;
    logic              armed;
    logic [1:0]        flush;

    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] wdata_r;

    logic              mode_chg, panel_ok, btn_sel;
    logic              act_addr, act_data;

    assign a_s      = a_sync[1];
    assign d_s      = d_sync[1];
    assign mode_chg = bus.prog_mode ^ prog_q;
    // Panel actions only in a settled program-mode cycle, never on the switch cycle.
    assign panel_ok = bus.prog_mode & ~mode_chg;
    assign btn_sel  = sel_data ? d_s : a_s;
    assign act_addr = panel_ok && (state == ACT) && !sel_data;
    assign act_data = panel_ok && (state == ACT) &&  sel_data;

    // Button synchronizers, mode tracking, and post-reset re-arm.
    // After reset a button must be seen released before a new press counts;
    // flush covers the synchronizer depth so stale zeros cannot arm early.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sync <= '0;
            d_sync <= '0;
            prog_q <= 1'b0;
            flush  <= 2'd2;
            armed  <= 1'b0;
        end else begin
            a_sync <= {a_sync[0], bus.addr_button};
            d_sync <= {d_sync[0], bus.data_button};
            prog_q <= bus.prog_mode;
            if (flush != 2'd0)
                flush <= flush - 2'd1;
            else if (!a_s && !d_s)
                armed <= 1'b1;
        end
    end

    // Panel FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            sel_data <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            sel_data <= sel_data_nxt;
        end
    end

    // Panel FSM next state: debounce press, act once, debounce release.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        sel_data_nxt = sel_data;
        wdata_load   = 1'b0;
        if (!panel_ok) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (armed && (a_s || d_s)) begin
                        state_nxt    = DEB;
                        cnt_nxt      = '0;
                        sel_data_nxt = !a_s;   // address button wins a tie
                    end
                end
                DEB: begin
                    if (!btn_sel) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt  = ACT;
                        cnt_nxt    = '0;
                        wdata_load = sel_data;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ACT: begin
                    state_nxt = REL;
                    cnt_nxt   = '0;
                end
                REL: begin
                    if (a_s || d_s)
                        cnt_nxt = '0;
                    else if (cnt == CNT_LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else
                        cnt_nxt = cnt + CNT_W'(1);
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // MAR and panel write-data registers. In run mode a MI+RI cycle writes at
    // the old MAR because the new address only lands at this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            mar     <= '0;
            wdata_r <= '0;
        end else begin
            if (wdata_load)
                wdata_r <= bus.dipswitch_data;
            if (!bus.prog_mode && bus.cpu_mi)
                mar <= bus.bus_in[ADDR_W-1:0];
            else if (act_addr)
                mar <= bus.dipswitch_addr;
`ifdef AUTO_INC_EN
            else if (act_data)
                mar <= mar + ADDR_W'(1);
`endif
        end
    end

    // RAM-side outputs: panel write strobe in program mode, CPU passthrough in run mode.
    always_comb begin
        bus.ram_we    = 1'b0;
        bus.ram_oe    = 1'b0;
        bus.ram_wdata = '0;
        if (!reset) begin
            if (bus.prog_mode) begin
                bus.ram_we    = act_data;
                bus.ram_wdata = wdata_r;
            end else begin
                bus.ram_we    = bus.cpu_ri & ~mode_chg;
                bus.ram_oe    = bus.cpu_ro & ~bus.cpu_ri;
                bus.ram_wdata = bus.bus_in;
            end
        end
    end

    assign bus.ram_addr = mar;
    assign bus.busy     = (state != IDLE);

endmodule
